// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - IF->ID / PC sequencing controller: stall, flush, halt.
module pipeline_ctrl #(
  parameter int INST_LEN     = 16,
  parameter int MUL_CYCLES   = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             branch_taken,
  input  logic             mc_start,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             busy,
  output logic             mc_done,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_MULTI = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] MUL_LOAD   = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  if (MUL_CYCLES < 1 || MUL_CYCLES > 16 || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4 ||
      INST_LEN < 1 || CNT_W < 1) begin : g_param_check
    $error("pipeline_ctrl: parameter out of range");
  end

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_mc_done;
  logic [CNT_W-1:0] r_stall_count;

  logic [1:0]       w_state_nxt;
  logic [3:0]       w_cnt_nxt;
  logic             w_mc_done_nxt;
  logic             w_stall;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mc_done_nxt = 1'b0;
    case (r_state)
      S_RUN: begin
        if (branch_taken) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = FLUSH_LOAD;
        end else if (mc_start) begin
          w_state_nxt = S_MULTI;
          w_cnt_nxt   = MUL_LOAD;
        end else if (halt_req) begin
          w_state_nxt = S_HALT;
        end
      end
      S_FLUSH: begin
        // A fresh taken branch restarts the bubble sequence.
        if (branch_taken) begin
          w_cnt_nxt = FLUSH_LOAD;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_MULTI: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt   = S_RUN;
          w_mc_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        if (resume) begin
          w_state_nxt = S_RUN;
        end
      end
    endcase
  end

  assign w_stall = (r_state == S_MULTI) || (r_state == S_HALT);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state       <= S_RUN;
      r_cnt         <= 4'd0;
      r_mc_done     <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mc_done <= w_mc_done_nxt;
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign pc_en       = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign if_id_en    = pc_en;
  assign if_id_flush = (r_state == S_FLUSH);
  assign busy        = (r_state == S_MULTI);
  assign halted      = (r_state == S_HALT);
  assign mc_done     = r_mc_done;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl.
module tb_pipeline_ctrl;

  // Output vector order: {pc_en, if_id_en, if_id_flush, busy, mc_done, halted}
  localparam logic [5:0] E_RUN  = 6'b110000;
  localparam logic [5:0] E_DONE = 6'b110010;
  localparam logic [5:0] E_FLSH = 6'b111000;
  localparam logic [5:0] E_MULT = 6'b000100;
  localparam logic [5:0] E_HALT = 6'b000001;

  typedef struct {
    logic [5:0]  vec;
    logic [15:0] stall;
  } exp_t;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic branch_taken = 1'b0;
  logic mc_start = 1'b0;
  logic halt_req = 1'b0;
  logic resume = 1'b0;

  logic        a_pc_en, a_if_id_en, a_if_id_flush, a_busy, a_mc_done, a_halted;
  logic [15:0] a_stall_count;
  logic        b_pc_en, b_if_id_en, b_if_id_flush, b_busy, b_mc_done, b_halted;
  logic [3:0]  b_stall_count;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  bit   sel_b = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.INST_LEN(16), .MUL_CYCLES(4), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .nReset(nReset), .branch_taken(branch_taken), .mc_start(mc_start),
    .halt_req(halt_req), .resume(resume), .pc_en(a_pc_en), .if_id_en(a_if_id_en),
    .if_id_flush(a_if_id_flush), .busy(a_busy), .mc_done(a_mc_done), .halted(a_halted),
    .stall_count(a_stall_count)
  );

  pipeline_ctrl #(.INST_LEN(16), .MUL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .nReset(nReset), .branch_taken(branch_taken), .mc_start(mc_start),
    .halt_req(halt_req), .resume(resume), .pc_en(b_pc_en), .if_id_en(b_if_id_en),
    .if_id_flush(b_if_id_flush), .busy(b_busy), .mc_done(b_mc_done), .halted(b_halted),
    .stall_count(b_stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic push(input logic [5:0] vec, input logic [15:0] stall);
    exp_t e;
    e.vec   = vec;
    e.stall = stall;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    if (sel_b) begin
      check("b_outputs", {26'd0, b_pc_en, b_if_id_en, b_if_id_flush, b_busy, b_mc_done, b_halted},
            {26'd0, e.vec});
      check("b_stall_count", {28'd0, b_stall_count}, {16'd0, e.stall});
    end else begin
      check("a_outputs", {26'd0, a_pc_en, a_if_id_en, a_if_id_flush, a_busy, a_mc_done, a_halted},
            {26'd0, e.vec});
      check("a_stall_count", {16'd0, a_stall_count}, {16'd0, e.stall});
    end
  endtask

  // Called at a negedge: apply inputs, expect given outputs after the next rising edge.
  task automatic drive(input logic bt, input logic mc, input logic hr, input logic rs,
                       input logic [5:0] vec, input logic [15:0] stall);
    branch_taken = bt;
    mc_start     = mc;
    halt_req     = hr;
    resume       = rs;
    push(vec, stall);
    @(negedge clk);
    cyc++;
    sample();
  endtask

  initial begin
    @(negedge clk);
    push(E_RUN, 16'd0);
    sample();
    nReset = 1'b1;

    drive(0, 0, 0, 0, E_RUN, 16'd0);
    // Multi-cycle op; branch/halt during MULTI must be ignored.
    drive(0, 1, 0, 0, E_MULT, 16'd0);
    drive(1, 0, 1, 0, E_MULT, 16'd1);
    drive(0, 1, 0, 0, E_MULT, 16'd2);
    drive(0, 0, 0, 0, E_MULT, 16'd3);
    drive(0, 0, 0, 0, E_DONE, 16'd4);
    drive(0, 0, 0, 0, E_RUN,  16'd4);
    // Branch beats mc_start; mc_start in FLUSH ignored.
    drive(1, 1, 0, 0, E_FLSH, 16'd4);
    drive(0, 1, 1, 0, E_RUN,  16'd4);
    drive(0, 0, 0, 0, E_RUN,  16'd4);
    // Halt, counting, resume with halt_req still high.
    drive(0, 0, 1, 0, E_HALT, 16'd4);
    drive(0, 0, 1, 0, E_HALT, 16'd5);
    drive(0, 0, 1, 0, E_HALT, 16'd6);
    drive(0, 0, 1, 1, E_RUN,  16'd7);
    drive(0, 0, 1, 0, E_HALT, 16'd7);
    drive(0, 0, 0, 1, E_RUN,  16'd8);
    drive(0, 0, 0, 0, E_RUN,  16'd8);
    // Async reset two cycles into MULTI.
    drive(0, 1, 0, 0, E_MULT, 16'd8);
    drive(0, 0, 0, 0, E_MULT, 16'd9);
    @(posedge clk);
    #2 nReset = 1'b0;
    #1;
    push(E_RUN, 16'd0);
    sample();
    @(negedge clk);
    drive(0, 0, 0, 0, E_RUN, 16'd0);
    drive(0, 0, 0, 0, E_RUN, 16'd0);
    nReset = 1'b1;
    drive(0, 0, 0, 0, E_RUN, 16'd0);
    drive(0, 0, 0, 0, E_RUN, 16'd0);
    drive(0, 0, 0, 0, E_RUN, 16'd0);

    // Second instance: FLUSH_CYCLES=2, MUL_CYCLES=2, 4-bit stall counter.
    sel_b = 1'b1;
    drive(1, 0, 0, 0, E_FLSH, 16'd0);
    drive(0, 0, 0, 0, E_FLSH, 16'd0);
    drive(0, 0, 0, 0, E_RUN,  16'd0);
    drive(1, 0, 0, 0, E_FLSH, 16'd0);
    drive(0, 0, 1, 0, E_FLSH, 16'd0);
    drive(1, 0, 0, 0, E_FLSH, 16'd0);
    drive(0, 0, 0, 0, E_FLSH, 16'd0);
    drive(0, 0, 0, 0, E_RUN,  16'd0);
    drive(0, 1, 0, 0, E_MULT, 16'd0);
    drive(0, 0, 0, 0, E_MULT, 16'd1);
    drive(0, 0, 0, 0, E_DONE, 16'd2);
    drive(0, 0, 1, 0, E_HALT, 16'd2);
    for (int k = 1; k <= 16; k++) begin
      drive(0, 0, 0, 0, E_HALT, ((2 + k) > 15) ? 16'd15 : 16'(2 + k));
    end
    drive(0, 0, 0, 1, E_RUN, 16'd15);
    drive(0, 0, 0, 0, E_RUN, 16'd15);

    if (exp_q.size() != 0) check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
